// File: rtl/triangle_fb.sv
// triangle_fb: captures renderer pixels into an 8x8 bitmap, then scans rows out over valid/ready.
// Optional macro TRI_FB_DUP_CHECK_EN: flag duplicate pixels and count distinct pixels only.
module triangle_fb #(
  parameter int CLEAR_AFTER_DUMP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  input  logic       row_ready,
  output logic       row_valid,
  output logic [2:0] row_addr,
  output logic [7:0] row_data,
  output logic [6:0] pix_cnt,
  output logic       frame_done,
  output logic       ovf,
  output logic       dup_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_DUMP    = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;

  logic [2:0]      state;
  logic [7:0][7:0] bm;
  logic            accept;
  logic            count_en;
  logic [7:0]      px_mask;
  logic [7:0]      row0_next;

  assign accept = (state == S_COLLECT) || (state == S_DRAIN);

  always_comb begin
    px_mask   = 8'd1 << xo;
    // Row 0 is loaded on the same edge that may still write a lagging DRAIN pixel.
    row0_next = bm[3'd0] | ((po && (yo == 3'd0)) ? px_mask : 8'd0);
  end

`ifdef TRI_FB_DUP_CHECK_EN
  logic hit;
  logic dup_q;

  always_comb begin
    hit      = bm[yo][xo];
    count_en = accept && po && !hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_q <= 1'b0;
    end else if ((state == S_IDLE) && busy) begin
      dup_q <= 1'b0;
    end else if (accept && po && hit) begin
      dup_q <= 1'b1;
    end
  end

  assign dup_err = dup_q;
`else
  always_comb begin
    count_en = accept && po;
  end

  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bm         <= '0;
      row_valid  <= 1'b0;
      row_addr   <= 3'd0;
      row_data   <= 8'd0;
      pix_cnt    <= 7'd0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (po && !accept) begin
        ovf <= 1'b1;
      end
      if (accept && po) begin
        bm[yo][xo] <= 1'b1;
      end
      if (count_en && (pix_cnt != 7'd127)) begin
        pix_cnt <= pix_cnt + 7'd1;
      end
      case (state)
        S_IDLE: begin
          if (busy) begin
            state   <= S_COLLECT;
            pix_cnt <= 7'd0;
            if (CLEAR_AFTER_DUMP == 0) begin
              bm <= '0;
            end
          end
        end
        S_COLLECT: begin
          if (!busy) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state     <= S_DUMP;
          row_valid <= 1'b1;
          row_addr  <= 3'd0;
          row_data  <= row0_next;
        end
        S_DUMP: begin
          if (row_ready) begin
            if (row_addr == 3'd7) begin
              state      <= S_CLEAR;
              row_valid  <= 1'b0;
              row_addr   <= 3'd0;
              row_data   <= 8'd0;
              frame_done <= 1'b1;
            end else begin
              row_addr <= row_addr + 3'd1;
              row_data <= bm[row_addr + 3'd1];
            end
          end
        end
        S_CLEAR: begin
          state <= S_IDLE;
          if (CLEAR_AFTER_DUMP != 0) begin
            bm <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
